ckpt_free_list: RTL and testbench

N-wide physical-register free list with multiple branch checkpoints. It sits between rename (allocation) and retire (freeing): it hands out up to N physical register indices per cycle and accepts up to N freed indices per cycle. It holds NUM_CKPT head-pointer snapshots so that any in-flight branch can roll back allocation in a single cycle. It extends the single-snapshot free list with:
- flow-controlled allocation (grant ≤ request),
- a checkpoint table with save, restore and release,
- an exact availability count.

---
 rtl/ckpt_free_list.sv | 164 ++++++++++++++++
 tb/tb_ckpt_free_list.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ckpt_free_list.sv
// ckpt_free_list: N-wide physical-register free list with NUM_CKPT head-pointer
// checkpoints for single-cycle branch rollback.
// Optional feature macro: FREE_LIST_BYPASS_EN. When defined, registers freed in
// a cycle can be granted in that same cycle (lanes beyond the stored count are
// filled from free_idx[0..] in order). The default build has no bypass.
module ckpt_free_list #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned N         = 3,
  parameter int unsigned NUM_CKPT  = 4,
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned PREG_W    = 7
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [$clog2(N+1)-1:0]        alloc_req,
  output logic [$clog2(N+1)-1:0]        alloc_grant,
  output logic [N*PREG_W-1:0]           alloc_idx,
  input  logic [$clog2(N+1)-1:0]        free_num,
  input  logic [N*PREG_W-1:0]           free_idx,
  input  logic                          ckpt_save,
  output logic [$clog2(NUM_CKPT)-1:0]   ckpt_id,
  output logic                          ckpt_full,
  input  logic                          ckpt_restore,
  input  logic [$clog2(NUM_CKPT)-1:0]   restore_id,
  input  logic                          ckpt_release,
  input  logic [$clog2(NUM_CKPT)-1:0]   release_id,
  output logic [$clog2(DEPTH+1)-1:0]    num_avail
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned CK_W  = $clog2(NUM_CKPT);
  localparam int unsigned AV_W  = $clog2(DEPTH + 1);

  // Pool storage and pointers (MSB of each pointer is the wrap bit)
  logic [PREG_W-1:0] entries_q [DEPTH];
  logic [PREG_W-1:0] entries_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;

  // Checkpoint table
  logic [PTR_W-1:0]    ck_head_q [NUM_CKPT];
  logic [PTR_W-1:0]    ck_head_d [NUM_CKPT];
  logic [NUM_CKPT-1:0] ck_valid_q, ck_valid_d;
  logic [CK_W-1:0]     ck_ptr_q, ck_ptr_d;

  // Registered status outputs
  logic [AV_W-1:0] num_avail_q, num_avail_d;
  logic            ckpt_full_q, ckpt_full_d;

  // Combinational helpers
  logic [PTR_W-1:0] count;
  logic [PTR_W:0]   avail_now;
  logic [PTR_W-1:0] head_alloc;
  logic [CK_W-1:0]  ck_dist;

  // Grant sizing, granted lanes and pointer advance
  always_comb begin
    count     = tail_q - head_q;
    avail_now = {1'b0, count};
`ifdef FREE_LIST_BYPASS_EN
    avail_now = avail_now + (PTR_W+1)'(free_num);
`endif
    if (ckpt_restore) begin
      alloc_grant = '0;
    end else if ((PTR_W+1)'(alloc_req) > avail_now) begin
      alloc_grant = CNT_W'(avail_now);
    end else begin
      alloc_grant = alloc_req;
    end

    alloc_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (CNT_W'(i) < alloc_grant) begin
        alloc_idx[i*PREG_W +: PREG_W] = entries_q[IDX_W'(head_q[IDX_W-1:0] + IDX_W'(i))];
`ifdef FREE_LIST_BYPASS_EN
        // Lanes past the stored count come straight from this cycle's frees
        for (int unsigned j = 0; j < N; j++) begin
          if ((PTR_W+1)'(i) == ((PTR_W+1)'(count) + (PTR_W+1)'(j))) begin
            alloc_idx[i*PREG_W +: PREG_W] = free_idx[j*PREG_W +: PREG_W];
          end
        end
`endif
      end
    end

    head_alloc = head_q + PTR_W'(alloc_grant);
    head_d     = ckpt_restore ? ck_head_q[restore_id] : head_alloc;
    tail_d     = tail_q + PTR_W'(free_num);
  end

  // Freed indices land at the tail
  always_comb begin
    entries_d = entries_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (CNT_W'(i) < free_num) begin
        entries_d[IDX_W'(tail_q[IDX_W-1:0] + IDX_W'(i))] = free_idx[i*PREG_W +: PREG_W];
      end
    end
  end

  // Checkpoint save / restore / release; restore outranks save
  always_comb begin
    ck_valid_d = ck_valid_q;
    ck_head_d  = ck_head_q;
    ck_ptr_d   = ck_ptr_q;
    ck_dist    = ck_ptr_q - restore_id;
    if (ckpt_release) begin
      ck_valid_d[release_id] = 1'b0;
    end
    if (ckpt_restore) begin
      // Drop the restored slot and every younger one; zero distance means a full table
      for (int unsigned j = 0; j < NUM_CKPT; j++) begin
        if ((ck_dist == '0) || (CK_W'(CK_W'(j) - restore_id) < ck_dist)) begin
          ck_valid_d[j] = 1'b0;
        end
      end
      ck_ptr_d = restore_id;
    end else if (ckpt_save && !ck_valid_q[ck_ptr_q]) begin
      ck_head_d[ck_ptr_q]  = head_alloc;
      ck_valid_d[ck_ptr_q] = 1'b1;
      ck_ptr_d             = ck_ptr_q + CK_W'(1);
    end
  end

  // Next values of the registered status outputs
  always_comb begin
    num_avail_d = AV_W'(tail_d - head_d);
    ckpt_full_d = ck_valid_d[ck_ptr_d];
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i] <= PREG_W'(ARCH_REGS + i);
      end
      for (int unsigned k = 0; k < NUM_CKPT; k++) begin
        ck_head_q[k] <= '0;
      end
      head_q      <= '0;
      tail_q      <= PTR_W'(DEPTH);
      ck_valid_q  <= '0;
      ck_ptr_q    <= '0;
      num_avail_q <= AV_W'(DEPTH);
      ckpt_full_q <= 1'b0;
    end else begin
      entries_q   <= entries_d;
      ck_head_q   <= ck_head_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      ck_valid_q  <= ck_valid_d;
      ck_ptr_q    <= ck_ptr_d;
      num_avail_q <= num_avail_d;
      ckpt_full_q <= ckpt_full_d;
    end
  end

  assign ckpt_id   = ck_ptr_q;
  assign ckpt_full = ckpt_full_q;
  assign num_avail = num_avail_q;

endmodule

// File: tb/tb_ckpt_free_list.sv
// Testbench for ckpt_free_list: behavioural pool model (unbounded history
// queue plus a head position) checked every cycle, plus directed literals.
`timescale 1ns/1ps
module tb_ckpt_free_list;

  localparam int unsigned DEPTH     = 32;
  localparam int unsigned N         = 3;
  localparam int unsigned NUM_CKPT  = 4;
  localparam int unsigned ARCH_REGS = 32;
  localparam int unsigned PREG_W    = 7;
  localparam int unsigned CNT_W     = $clog2(N + 1);
  localparam int unsigned CK_W      = $clog2(NUM_CKPT);
  localparam int unsigned AV_W      = $clog2(DEPTH + 1);

  logic                clock = 1'b0;
  logic                reset;
  logic [CNT_W-1:0]    alloc_req;
  logic [CNT_W-1:0]    alloc_grant;
  logic [N*PREG_W-1:0] alloc_idx;
  logic [CNT_W-1:0]    free_num;
  logic [N*PREG_W-1:0] free_idx;
  logic                ckpt_save;
  logic [CK_W-1:0]     ckpt_id;
  logic                ckpt_full;
  logic                ckpt_restore;
  logic [CK_W-1:0]     restore_id;
  logic                ckpt_release;
  logic [CK_W-1:0]     release_id;
  logic [AV_W-1:0]     num_avail;

  ckpt_free_list #(
    .DEPTH(DEPTH), .N(N), .NUM_CKPT(NUM_CKPT), .ARCH_REGS(ARCH_REGS), .PREG_W(PREG_W)
  ) dut (
    .clock(clock), .reset(reset),
    .alloc_req(alloc_req), .alloc_grant(alloc_grant), .alloc_idx(alloc_idx),
    .free_num(free_num), .free_idx(free_idx),
    .ckpt_save(ckpt_save), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
    .ckpt_restore(ckpt_restore), .restore_id(restore_id),
    .ckpt_release(ckpt_release), .release_id(release_id),
    .num_avail(num_avail)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: every index ever placed in the pool, in order; hd is the allocation position
  int hist[$];
  int hd;
  int ck_hd [NUM_CKPT];
  bit ck_v  [NUM_CKPT];
  int ck_p;
  bit ready   = 1'b0;
  bit wrap_on = 1'b0;
  bit outst [128];
  int gn[$];
  int gl[$];
  int exp_l [N];

  function automatic int lane(input logic [N*PREG_W-1:0] v, input int k);
    return int'(v[k*PREG_W +: PREG_W]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, then model advance
  always @(negedge clock) begin : cmp
    int cnt, avail, g, p, fn, nh, j;
    if (reset) begin
      hist.delete();
      for (int i = 0; i < DEPTH; i++) hist.push_back(ARCH_REGS + i);
      hd   = 0;
      ck_p = 0;
      for (int i = 0; i < NUM_CKPT; i++) begin
        ck_v[i]  = 1'b0;
        ck_hd[i] = 0;
      end
      ready = 1'b1;
    end else if (ready) begin
      cnt   = hist.size() - hd;
      fn    = int'(free_num);
      avail = cnt;
`ifdef FREE_LIST_BYPASS_EN
      avail = cnt + fn;
`endif
      g = ckpt_restore ? 0 : ((int'(alloc_req) < avail) ? int'(alloc_req) : avail);
      chk("alloc_grant", int'(alloc_grant), g);
      for (int i = 0; i < N; i++) begin
        p = hd + i;
        if (i >= g) exp_l[i] = 0;
        else if (p < hist.size()) exp_l[i] = hist[p];
        else exp_l[i] = lane(free_idx, p - hist.size());
        chk($sformatf("alloc_idx[%0d]", i), lane(alloc_idx, i), exp_l[i]);
      end
      chk("ckpt_id", int'(ckpt_id), ck_p);
      chk("ckpt_full", int'(ckpt_full), int'(ck_v[ck_p]));
      chk("num_avail", int'(num_avail), cnt);

      if (wrap_on) begin
        for (int i = 0; i < fn; i++) outst[lane(free_idx, i)] = 1'b0;
        for (int i = 0; i < g; i++) begin
          chk("dup_outstanding", int'(outst[lane(alloc_idx, i)]), 0);
          outst[lane(alloc_idx, i)] = 1'b1;
        end
        gn.push_back(g);
        for (int i = 0; i < g; i++) gl.push_back(exp_l[i]);
      end

      for (int i = 0; i < fn; i++) hist.push_back(lane(free_idx, i));
      nh = hd + g;
      if (ckpt_release) ck_v[release_id] = 1'b0;
      if (ckpt_restore) begin
        j = int'(restore_id);
        do begin
          ck_v[j] = 1'b0;
          j = (j + 1) % NUM_CKPT;
        end while (j != ck_p);
        ck_p = int'(restore_id);
        nh   = ck_hd[restore_id];
      end else if (ckpt_save && !ck_v[ck_p]) begin
        ck_hd[ck_p] = nh;
        ck_v[ck_p]  = 1'b1;
        ck_p        = (ck_p + 1) % NUM_CKPT;
      end
      hd = nh;
    end
  end

  task automatic zero_inputs();
    alloc_req    = '0;
    free_num     = '0;
    free_idx     = '0;
    ckpt_save    = 1'b0;
    ckpt_restore = 1'b0;
    restore_id   = '0;
    ckpt_release = 1'b0;
    release_id   = '0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    zero_inputs();
    @(posedge clock); #1;
  endtask

  // One cycle of stimulus; returns 2 ns after the edge for literal checks
  task automatic drive(input int req, input int fn, input int f0, input int f1, input int f2,
                       input bit sv, input bit rs, input int rid, input bit rl, input int lid);
    @(posedge clock); #1;
    reset        = 1'b0;
    alloc_req    = CNT_W'(req);
    free_num     = CNT_W'(fn);
    free_idx     = {PREG_W'(f2), PREG_W'(f1), PREG_W'(f0)};
    ckpt_save    = sv;
    ckpt_restore = rs;
    restore_id   = CK_W'(rid);
    ckpt_release = rl;
    release_id   = CK_W'(lid);
    #1;
  endtask

  task automatic alloc(input int req);
    drive(req, 0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic save();
    drive(0, 0, 0, 0, 0, 1'b1, 1'b0, 0, 1'b0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    zero_inputs();
    do_reset();

    // Reset state, then allocate 3 twice
    alloc(0);
    chk("rst_grant", int'(alloc_grant), 0);
    chk("rst_idx", int'(alloc_idx), 0);
    chk("rst_avail", int'(num_avail), 32);
    chk("rst_full", int'(ckpt_full), 0);
    chk("rst_id", int'(ckpt_id), 0);
    alloc(3);
    chk("a1_grant", int'(alloc_grant), 3);
    chk("a1_l0", lane(alloc_idx, 0), 32);
    chk("a1_l1", lane(alloc_idx, 1), 33);
    chk("a1_l2", lane(alloc_idx, 2), 34);
    alloc(3);
    chk("a2_l0", lane(alloc_idx, 0), 35);
    chk("a2_l2", lane(alloc_idx, 2), 37);
    chk("a2_avail", int'(num_avail), 29);
    alloc(0);
    chk("a3_avail", int'(num_avail), 26);

    // Save at head 4 with 2 allocated, allocate 5 more, restore
    do_reset();
    alloc(3);
    alloc(1);
    drive(2, 0, 0, 0, 0, 1'b1, 1'b0, 0, 1'b0, 0);
    chk("sv_id", int'(ckpt_id), 0);
    chk("sv_l0", lane(alloc_idx, 0), 36);
    alloc(3);
    chk("sv_id_next", int'(ckpt_id), 1);
    alloc(2);
    drive(3, 0, 0, 0, 0, 1'b0, 1'b1, 0, 1'b0, 0);
    chk("rs_grant", int'(alloc_grant), 0);
    chk("rs_avail_before", int'(num_avail), 21);
    alloc(1);
    chk("rs_l0", lane(alloc_idx, 0), 38);
    chk("rs_avail", int'(num_avail), 26);

    // Drain to one entry, then empty, then free two
    for (int k = 0; k < 8; k++) alloc(3);
    alloc(3);
    chk("dr_avail1", int'(num_avail), 1);
    chk("dr_grant1", int'(alloc_grant), 1);
    chk("dr_l0", lane(alloc_idx, 0), 63);
    alloc(3);
    chk("dr_grant0", int'(alloc_grant), 0);
    drive(3, 2, 40, 41, 0, 1'b0, 1'b0, 0, 1'b0, 0);
`ifdef FREE_LIST_BYPASS_EN
    chk("dr_byp_grant", int'(alloc_grant), 2);
    chk("dr_byp_l0", lane(alloc_idx, 0), 40);
    chk("dr_byp_l1", lane(alloc_idx, 1), 41);
`else
    chk("dr_same_grant", int'(alloc_grant), 0);
`endif
    alloc(3);
`ifdef FREE_LIST_BYPASS_EN
    chk("dr_next_grant", int'(alloc_grant), 0);
`else
    chk("dr_next_grant", int'(alloc_grant), 2);
    chk("dr_next_l0", lane(alloc_idx, 0), 40);
    chk("dr_next_l1", lane(alloc_idx, 1), 41);
`endif
    alloc(0);

    // Nested restore, full table, release and conflicts
    do_reset();
    save();
    chk("n_id0", int'(ckpt_id), 0);
    save();
    chk("n_id1", int'(ckpt_id), 1);
    save();
    chk("n_id2", int'(ckpt_id), 2);
    drive(0, 0, 0, 0, 0, 1'b0, 1'b1, 1, 1'b0, 0);
    save();
    chk("n_resave_id", int'(ckpt_id), 1);
    chk("n_resave_full", int'(ckpt_full), 0);
    save();
    save();
    alloc(0);
    chk("f_id", int'(ckpt_id), 0);
    chk("f_full", int'(ckpt_full), 1);
    save();
    alloc(0);
    chk("f_drop_id", int'(ckpt_id), 0);
    drive(0, 0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b1, 0);
    chk("f_rel_full_old", int'(ckpt_full), 1);
    save();
    chk("f_rel_full", int'(ckpt_full), 0);
    alloc(0);
    chk("f_acc_id", int'(ckpt_id), 1);
    chk("f_acc_full", int'(ckpt_full), 1);
    drive(0, 0, 0, 0, 0, 1'b1, 1'b1, 1, 1'b1, 0);
    alloc(0);
    chk("c_id", int'(ckpt_id), 1);
    chk("c_full", int'(ckpt_full), 0);
    save();
    save();
    drive(0, 0, 0, 0, 0, 1'b0, 1'b1, 3, 1'b1, 1);
    save();
    chk("c_id3", int'(ckpt_id), 3);
    save();
    chk("c_id0", int'(ckpt_id), 0);
    alloc(0);
    chk("c_rel_id", int'(ckpt_id), 1);
    chk("c_rel_full", int'(ckpt_full), 0);

    // Wrap-around: random allocation, frees mirror grants five cycles later
    do_reset();
    for (int t = 0; t < 105; t++) begin
      @(posedge clock); #1;
      reset   = 1'b0;
      wrap_on = 1'b1;
      zero_inputs();
      alloc_req = (t < 100) ? CNT_W'($urandom_range(0, 3)) : '0;
      if (t >= 5) begin
        if (gn.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wrap_record: got none expected a grant record");
        end else begin
          int n;
          n = gn.pop_front();
          free_num = CNT_W'(n);
          for (int k = 0; k < n; k++) free_idx[k*PREG_W +: PREG_W] = PREG_W'(gl.pop_front());
        end
      end
    end
    @(posedge clock); #1;
    wrap_on = 1'b0;
    zero_inputs();
    alloc(0);
    chk("wrap_final_avail", int'(num_avail), 32);
    alloc(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
